// File: rtl/key_schedule_ctrl_pkg.sv
// key_schedule_ctrl_pkg
// Shared AES-128 key-schedule definitions: round-key count, last key index,
// controller state encoding and the round-constant table used by expandkey.
package key_schedule_ctrl_pkg;

   localparam int         AES_NUM_KEYS = 11;
   localparam logic [3:0] AES_LAST_IDX = 4'd10;

   typedef enum logic [1:0] {
      KS_IDLE = 2'd0,
      KS_EMIT = 2'd1,
      KS_REQ  = 2'd2,
      KS_WAIT = 2'd3
   } ks_state_e;

   // Round constant for round r lives in byte r ([8r+7:8r]), rounds 0..9.
   localparam logic [79:0] AES_RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   // Round constant lookup; rounds beyond 9 have no constant and return 0.
   function automatic logic [7:0] aes_rcon(input logic [3:0] round_i);
      logic [7:0] rc;
      if (round_i <= 4'd9) begin
         rc = AES_RCON[{round_i, 3'b000} +: 8];
      end else begin
         rc = 8'h00;
      end
      return rc;
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_expandkey.sv
// expandkey
// Combinational AES-128 next-round-key stage.
// Ports:
//   round_in   : round number 0..9, selects the round constant
//   key_in     : previous round key, byte i at [8i+7:8i], word j at [32j+31:32j]
//   subword_in : SubWord(word 3 of key_in), supplied by the shared S-box unit
//   key_out    : next round key, same byte order
module expandkey
   import key_schedule_ctrl_pkg::*;
(
   input  logic [3:0]   round_in,
   input  logic [127:0] key_in,
   input  logic [31:0]  subword_in,
   output logic [127:0] key_out
);

   logic [31:0] rot_s;
   logic [31:0] temp_s;
   logic [31:0] w0_s;
   logic [31:0] w1_s;
   logic [31:0] w2_s;
   logic [31:0] w3_s;

   // SubWord is bytewise, so rotating its result equals SubWord(RotWord(w)).
   // With byte 0 in the low bits, RotWord moves byte 1 down to the bottom.
   assign rot_s  = {subword_in[7:0], subword_in[31:8]};
   assign temp_s = rot_s ^ {24'h000000, aes_rcon(round_in)};

   assign w0_s = key_in[31:0]   ^ temp_s;
   assign w1_s = key_in[63:32]  ^ w0_s;
   assign w2_s = key_in[95:64]  ^ w1_s;
   assign w3_s = key_in[127:96] ^ w2_s;

   assign key_out = {w3_s, w2_s, w1_s, w0_s};

endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
// Sequences expandkey over AES-128 rounds 0..9 and streams the 11 round keys
// to the cipher datapath, borrowing a shared SubWord unit via req/gnt.
// Ports:
//   clk_in, rst_in            : clock (rising edge), async active-high reset
//   start_in, abort_in        : begin expansion (IDLE only) / return to IDLE
//   key_in                    : cipher key
//   busy_out, done_out        : not-IDLE flag / pulse after key 10 accepted
//   rkey_out, rkey_idx_out    : current round key and its index 0..10
//   rkey_valid_out/ready_in   : round-key stream handshake
//   sbox_req_out/gnt_in       : shared SubWord unit arbitration
//   sbox_word_out/word_in     : SubWord operand (key bits [127:96]) / result
module key_schedule_ctrl
   import key_schedule_ctrl_pkg::*;
#(
   parameter int SBOX_LAT = 1,
   parameter int NUM_KEYS = AES_NUM_KEYS
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         start_in,
   input  logic         abort_in,
   input  logic [127:0] key_in,
   output logic         busy_out,
   output logic         done_out,
   output logic [127:0] rkey_out,
   output logic [3:0]   rkey_idx_out,
   output logic         rkey_valid_out,
   input  logic         rkey_ready_in,
   output logic         sbox_req_out,
   input  logic         sbox_gnt_in,
   output logic [31:0]  sbox_word_out,
   input  logic [31:0]  sbox_word_in
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);
   localparam logic [2:0] LAT_LOAD = 3'(SBOX_LAT);

   ks_state_e    state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic [2:0]   lat_q, lat_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         valid_q, valid_d;
   logic         req_q, req_d;
   logic [127:0] next_key_s;

   expandkey u_expandkey (
      .round_in   (round_q),
      .key_in     (key_q),
      .subword_in (sbox_word_in),
      .key_out    (next_key_s)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      lat_d   = lat_q;
      done_d  = 1'b0;

      if (abort_in) begin
         // Abort beats start, handshake and a result landing this cycle.
         state_d = KS_IDLE;
         lat_d   = 3'd0;
      end else begin
         case (state_q)
            KS_IDLE: begin
               if (start_in) begin
                  key_d   = key_in;
                  round_d = 4'd0;
                  state_d = KS_EMIT;
               end else begin
                  state_d = KS_IDLE;
               end
            end
            KS_EMIT: begin
               if (rkey_ready_in) begin
                  if (round_q == LAST_IDX) begin
                     state_d = KS_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = KS_REQ;
                  end
               end else begin
                  state_d = KS_EMIT;
               end
            end
            KS_REQ: begin
               if (sbox_gnt_in) begin
                  state_d = KS_WAIT;
                  lat_d   = LAT_LOAD;
               end else begin
                  state_d = KS_REQ;
               end
            end
            KS_WAIT: begin
               // lat_q == 1 marks the cycle in which sbox_word_in is valid.
               if (lat_q == 3'd1) begin
                  key_d   = next_key_s;
                  round_d = round_q + 4'd1;
                  lat_d   = 3'd0;
                  state_d = KS_EMIT;
               end else begin
                  lat_d   = lat_q - 3'd1;
               end
            end
            default: begin
               state_d = KS_IDLE;
            end
         endcase
      end

      busy_d  = (state_d != KS_IDLE);
      valid_d = (state_d == KS_EMIT);
      req_d   = (state_d == KS_REQ);
   end

   // State, key, counters and output flags.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= KS_IDLE;
         key_q   <= 128'd0;
         round_q <= 4'd0;
         lat_q   <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         lat_q   <= lat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign busy_out       = busy_q;
   assign done_out       = done_q;
   assign rkey_out       = key_q;
   assign rkey_idx_out   = round_q;
   assign rkey_valid_out = valid_q;
   assign sbox_req_out   = req_q;
   assign sbox_word_out  = key_q[127:96];

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Testbench for key_schedule_ctrl: a SBOX_LAT=1 instance driven through all
// scenarios and a SBOX_LAT=3 instance run alongside on the vector table.
module tb_key_schedule_ctrl;

   typedef logic [131:0] hs_t;
   typedef struct {
      logic [127:0] key_s;
      int           idx;
      logic [127:0] exp_s;
   } vec_t;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b1;
   logic         start1, abort1, ready1, gnt1, start3, abort3, ready3, gnt3;
   logic [127:0] key_in;
   logic [31:0]  sbox_in1, sbox_in3;
   logic         busy1, done1, valid1, req1, busy3, done3, valid3, req3;
   logic [127:0] rkey1, rkey3;
   logic [3:0]   idx1, idx3;
   logic [31:0]  sbox_out1, sbox_out3;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rdy_mode = 0, gnt_mode = 0, hold = 0, wcnt = 0, rlen = 0;
   int done_cnt1 = 0, done_cnt3 = 0, done_cyc1 = 0, done_cyc3 = 0;
   int due1 = -1, due3 = -1;
   logic [31:0]  op1, op3;
   logic [127:0] mdl [0:10];
   hs_t q1[$];
   hs_t q3[$];
   vec_t vecs[5];

   always #5 clk_in = ~clk_in;

   key_schedule_ctrl #(.SBOX_LAT(1)) u_dut1 (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start1), .abort_in(abort1),
      .key_in(key_in), .busy_out(busy1), .done_out(done1), .rkey_out(rkey1),
      .rkey_idx_out(idx1), .rkey_valid_out(valid1), .rkey_ready_in(ready1),
      .sbox_req_out(req1), .sbox_gnt_in(gnt1), .sbox_word_out(sbox_out1),
      .sbox_word_in(sbox_in1));

   key_schedule_ctrl #(.SBOX_LAT(3)) u_dut3 (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start3), .abort_in(abort3),
      .key_in(key_in), .busy_out(busy3), .done_out(done3), .rkey_out(rkey3),
      .rkey_idx_out(idx3), .rkey_valid_out(valid3), .rkey_ready_in(ready3),
      .sbox_req_out(req3), .sbox_gnt_in(gnt3), .sbox_word_out(sbox_out3),
      .sbox_word_in(sbox_in3));

   // ---------------- GF(2^8) S-box and FIPS-197 key expansion model ----------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] r;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte stream as written in FIPS-197 (first byte leftmost) -> port layout.
   function automatic logic [127:0] s2k(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = s[127-8*i -: 8];
      return r;
   endfunction

   task automatic build_model(input logic [127:0] key);
      logic [7:0] b [0:175];
      logic [7:0] t [0:3];
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) b[i] = key[8*i +: 8];
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) t[j] = b[i-4+j];
         if (i % 16 == 0) begin
            t[0] = sbox(b[i-3]) ^ rc;
            t[1] = sbox(b[i-2]);
            t[2] = sbox(b[i-1]);
            t[3] = sbox(b[i-4]);
            rc = xt(rc);
         end
         for (int j = 0; j < 4; j++) b[i+j] = b[i-16+j] ^ t[j];
      end
      for (int r = 0; r < 11; r++)
         for (int j = 0; j < 16; j++) mdl[r][8*j +: 8] = b[16*r + j];
   endtask

   // ---------------- checking and cycle engine -------------------------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Observes the DUTs at the falling edge, with inputs settled for the next edge.
   task automatic sample();
      if (!rst_in) begin
         if (valid1 && ready1 && !abort1) q1.push_back({idx1, rkey1});
         if (valid1) begin
            if (idx1 <= 4'd10) chk("rkey_vs_idx", rkey1, mdl[idx1]);
            else chk("idx_range", 128'(idx1), 128'd10);
            if (!ready1) chk("req_while_stalled", 128'(req1), 128'd0);
         end
         if (req1 && idx1 <= 4'd10) chk("sbox_word_out", 128'(sbox_out1), 128'(mdl[idx1][127:96]));
         if (req1 && gnt1) begin due1 = cyc + 1; op1 = sbox_out1; end
         if (req1) rlen++;
         else begin
            if (rlen != 0 && gnt_mode == 2) chk("req_len", 128'(rlen), 128'd8);
            rlen = 0;
         end
         if (done1) begin done_cnt1++; done_cyc1 = cyc; end
         if (valid3 && ready3) q3.push_back({idx3, rkey3});
         if (req3 && gnt3) begin due3 = cyc + 3; op3 = sbox_out3; end
         if (done3) begin done_cnt3++; done_cyc3 = cyc; end
      end
   endtask

   // Drives the environment just after the rising edge.
   task automatic drive();
      sbox_in1 = (cyc == due1) ? sub_word(op1) : $urandom();
      sbox_in3 = (cyc == due3) ? sub_word(op3) : $urandom();
      case (rdy_mode)
         1: ready1 = 1'($urandom_range(0, 1));
         2: begin
            if (valid1 && idx1 == 4'd3 && hold < 5) begin ready1 = 1'b0; hold++; end
            else ready1 = 1'b1;
         end
         default: ready1 = 1'b1;
      endcase
      case (gnt_mode)
         1: gnt1 = 1'($urandom_range(0, 1));
         2: begin
            if (req1) wcnt++; else wcnt = 0;
            gnt1 = (wcnt > 7);
         end
         default: gnt1 = 1'b1;
      endcase
   endtask

   task automatic tick();
      @(negedge clk_in);
      sample();
      @(posedge clk_in);
      cyc++;
      #1;
      drive();
   endtask

   task automatic check_stream(input string tag, input hs_t q[$]);
      chk({tag, "_count"}, 128'(q.size()), 128'd11);
      for (int i = 0; i < q.size() && i < 11; i++) begin
         chk({tag, "_idx"}, 128'(q[i][131:128]), 128'(i));
         chk({tag, "_key"}, q[i][127:0], mdl[i]);
      end
   endtask

   task automatic run(input logic [127:0] key, input bit use3, input bit busy_start);
      int n;
      int s_edge;
      build_model(key);
      q1.delete();
      q3.delete();
      done_cnt1 = 0;
      done_cnt3 = 0;
      key_in = key;
      start1 = 1'b1;
      start3 = use3;
      tick();
      start1 = 1'b0;
      start3 = 1'b0;
      s_edge = cyc;
      n = 0;
      while (!(done_cnt1 > 0 && (!use3 || done_cnt3 > 0)) && n < 3000) begin
         if (busy_start && valid1 && idx1 == 4'd2) begin
            start1 = 1'b1;
            key_in = ~key;
         end else begin
            start1 = 1'b0;
         end
         tick();
         n++;
      end
      start1 = 1'b0;
      chk("run_timeout", 128'(n < 3000), 128'd1);
      repeat (3) tick();
      chk("done_pulses", 128'(done_cnt1), 128'd1);
      check_stream("dut1", q1);
      if (rdy_mode == 0 && gnt_mode == 0)
         chk("cycles_to_done", 128'(done_cyc1 - s_edge), 128'd31);
      if (use3) begin
         chk("lat3_done_pulses", 128'(done_cnt3), 128'd1);
         chk("lat3_cycles_to_done", 128'(done_cyc3 - s_edge), 128'd51);
         check_stream("lat3", q3);
      end
   endtask

   // ---------------- test sequence --------------------------------------------
   initial begin
      int n;
      logic [127:0] fips;
      logic [127:0] kb;
      fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      vecs[0] = '{fips, 1, 128'ha0fafe1788542cb123a339392a6c7605};
      vecs[1] = '{fips, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[2] = '{fips, 0, fips};
      vecs[3] = '{128'd0, 1, 128'h62636363626363636263636362636363};
      vecs[4] = '{128'd0, 2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};

      start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; gnt1 = 1'b1;
      start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b1; gnt3 = 1'b1;
      key_in = 128'd0; sbox_in1 = 32'd0; sbox_in3 = 32'd0;
      op1 = 32'd0; op3 = 32'd0;

      // Reset state
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_flags1", 128'({busy1, done1, valid1, req1, idx1, sbox_out1}), 128'd0);
      chk("rst_rkey1", rkey1, 128'd0);
      chk("rst_flags3", 128'({busy3, done3, valid3, req3, idx3, sbox_out3}), 128'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (2) tick();

      // Known-answer table, both latencies, constant ready/grant
      foreach (vecs[v]) begin
         run(s2k(vecs[v].key_s), 1'b1, 1'b0);
         chk("vec_key_lat1", q1[vecs[v].idx][127:0], s2k(vecs[v].exp_s));
         chk("vec_key_lat3", q3[vecs[v].idx][127:0], s2k(vecs[v].exp_s));
      end

      // Backpressure: ready low for 5 cycles at idx 3
      rdy_mode = 2;
      hold = 0;
      run(s2k(fips), 1'b0, 1'b0);
      chk("stall_cycles", 128'(hold), 128'd5);
      rdy_mode = 0;

      // Grant withheld 7 cycles per request, start pulsed while busy
      gnt_mode = 2;
      run(s2k(fips), 1'b0, 1'b1);
      chk("gnt_delay_key10", q1[10][127:0], s2k(vecs[1].exp_s));
      gnt_mode = 0;

      // Random keys, random ready and random grant (also outside REQ)
      rdy_mode = 1;
      gnt_mode = 1;
      for (int r = 0; r < 6; r++) run({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
      rdy_mode = 0;
      gnt_mode = 0;

      // Abort in WAIT at idx 5
      build_model(s2k(fips));
      q1.delete();
      done_cnt1 = 0;
      key_in = s2k(fips);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 0;
      while (!(busy1 && idx1 == 4'd5 && !valid1 && !req1) && n < 200) begin
         tick();
         n++;
      end
      chk("abort_reach_wait", 128'(n < 200), 128'd1);
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      chk("abort_flags", 128'({busy1, valid1, req1, done1}), 128'd0);
      chk("abort_key_kept", rkey1, mdl[5]);
      chk("abort_idx_kept", 128'(idx1), 128'd5);
      repeat (5) tick();
      chk("abort_no_done", 128'(done_cnt1), 128'd0);
      chk("abort_emitted", 128'(q1.size()), 128'd6);

      // Start together with abort in IDLE is ignored
      kb = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_in = kb;
      start1 = 1'b1;
      abort1 = 1'b1;
      tick();
      start1 = 1'b0;
      abort1 = 1'b0;
      tick();
      chk("abort_start_busy", 128'(busy1), 128'd0);
      chk("abort_start_key", rkey1, mdl[5]);
      run(kb, 1'b0, 1'b0);

      // Asynchronous reset asserted mid-REQ, between clock edges
      build_model(s2k(fips));
      key_in = s2k(fips);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 0;
      while (!(req1 && idx1 == 4'd4) && n < 200) begin
         tick();
         n++;
      end
      chk("rst_reach_req", 128'(n < 200), 128'd1);
      #2;
      rst_in = 1'b1;
      #1;
      chk("async_rst_flags", 128'({busy1, done1, valid1, req1, idx1, sbox_out1}), 128'd0);
      chk("async_rst_rkey", rkey1, 128'd0);
      #2;
      rst_in = 1'b0;
      tick();
      chk("post_rst_idle", 128'(busy1), 128'd0);
      run(s2k(fips), 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
